// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared constants for the memory stage and the decode controller:
//   - load type codes  (LT_*) as carried on mem_load_type
//   - store type codes (ST_*) as carried on mem_store_type
//   - FSM state encodings of mem_access_unit
//   - req_t: the request latched at access start and held on the bus
//   - helpers that build byte enables / replicated write data and
//     classify an access as misaligned
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

    localparam logic [2:0] LT_LB   = 3'b000;
    localparam logic [2:0] LT_LH   = 3'b001;
    localparam logic [2:0] LT_LW   = 3'b010;
    localparam logic [2:0] LT_LBU  = 3'b011;
    localparam logic [2:0] LT_LHU  = 3'b100;
    localparam logic [2:0] LT_NONE = 3'b111;

    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Everything about the access except the address, frozen at start.
    typedef struct packed {
        logic        we;
        logic [2:0]  ltype;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    // Halfword lanes follow addr[1] only, so addr[0] never shifts them.
    function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] off);
        logic [3:0] be;
        case (st)
            ST_SB:   be = 4'b0001 << off;
            ST_SH:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane it could land in; the
    // byte enables pick the lane, so the slave never needs to shift data.
    function automatic logic [31:0] store_lanes(input logic [1:0] st, input logic [31:0] d);
        logic [31:0] w;
        case (st)
            ST_SB:   w = {4{d[7:0]}};
            ST_SH:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic is_misaligned(input logic       is_load,
                                           input logic [2:0] lt,
                                           input logic [1:0] st,
                                           input logic [1:0] off);
        logic m;
        if (is_load) begin
            case (lt)
                LT_LH, LT_LHU: m = off[0];
                LT_LW:         m = (off != 2'b00);
                default:       m = 1'b0;
            endcase
        end else begin
            case (st)
                ST_SH:   m = off[0];
                ST_SW:   m = (off != 2'b00);
                default: m = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Word-aligned req/ack data bus between the memory stage and data memory.
//   bus_req   master->slave  request, held until bus_ack
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned byte address ([1:0] = 00)
//   bus_wdata master->slave  lane-replicated write data
//   bus_be    master->slave  byte enables
//   bus_rdata slave->master  read word, valid with bus_ack
//   bus_ack   slave->master  completion, meaningful only while bus_req = 1
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_be;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// -----------------------------------------------------------------------------
// mem_access_unit_load_formatter
// Purely combinational: selects the byte/halfword addressed by off from a bus
// word and sign- or zero-extends it according to the load type.
//   rdata_i  read word from the bus
//   ltype_i  load type code (LT_*)
//   off_i    byte offset within the word (addr[1:0])
//   data_o   extended load result (0 for non-load codes)
// -----------------------------------------------------------------------------
module mem_access_unit_load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  ltype_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // off_i[0] is deliberately ignored: halfwords are addressed by bit 1.
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (ltype_i)
            LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data_o = {24'd0, byte_sel};
            LT_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  data_o = {16'd0, half_sel};
            LT_LW:   data_o = rdata_i;
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage access engine. Turns one decoded load or store into a single
// word-aligned req/ack bus transaction and stalls the pipeline until it ends.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_write       store request from EX/MEM
//   wb_load         load request from EX/MEM (wins when both are set)
//   mem_load_type   LT_* code, LT_NONE = no load
//   mem_store_type  ST_* code, ST_NONE = no store
//   addr            byte address from the ALU
//   store_data      rs2 value
//   load_data       formatted load result, held until the next load completes
//   stall           hold front-end and EX/MEM (combinational in the start cycle)
//   done            one-cycle pulse when the access completes
//   misaligned      pulse together with done for a trapped access
//   bus             master side of mem_access_unit_if
//
// Build option
//   MISALIGN_TRAP_EN  misaligned halfword/word accesses skip the bus and
//                     finish in one stall cycle with misaligned = 1. Without
//                     it, misaligned is 0 and low address bits are ignored,
//                     so the access is forced aligned.
//
// Sequence: IDLE -(start)-> REQ -(bus_ack)-> DONE -> IDLE
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write,
    input  logic              wb_load,
    input  logic [2:0]        mem_load_type,
    input  logic [1:0]        mem_store_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    mem_access_unit_if.master bus
);

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    req_t              r_q,         r_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              req_q,       req_d;
    logic              done_q,      done_d;
    logic              mis_q,       mis_d;

    logic              is_load;
    logic              is_store;
    logic              start;
    logic              trap;
    logic [31:0]       fmt_data;

    assign is_load  = wb_load   && (mem_load_type  != LT_NONE);
    assign is_store = mem_write && (mem_store_type != ST_NONE);
    assign start    = is_load || is_store;

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(is_load, mem_load_type, mem_store_type, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Formats with the latched type/offset so the pipeline inputs may change
    // freely while the bus transaction is outstanding.
    mem_access_unit_load_formatter u_fmt (
        .rdata_i (bus.bus_rdata),
        .ltype_i (r_q.ltype),
        .off_i   (r_q.off),
        .data_o  (fmt_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        r_d         = r_q;
        load_data_d = load_data_q;
        req_d       = 1'b0;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        stall       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall = 1'b1;
                    if (trap) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d  = S_REQ;
                        req_d    = 1'b1;
                        addr_d   = {addr[ADDR_W-1:2], 2'b00};
                        r_d.we   = !is_load;
                        r_d.ltype = mem_load_type;
                        r_d.off  = addr[1:0];
                        r_d.be   = is_load ? 4'b1111 : store_be(mem_store_type, addr[1:0]);
                        r_d.wdata = is_load ? 32'd0 : store_lanes(mem_store_type, store_data);
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (!r_q.we) begin
                        load_data_d = fmt_data;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            // The pipeline advances on the edge leaving DONE, so the same
            // instruction is still presented here and must not restart.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            r_q         <= '0;
            load_data_q <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            r_q         <= r_d;
            load_data_q <= load_data_d;
            req_q       <= req_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = r_q.we;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = r_q.wdata;
    assign bus.bus_be    = r_q.be;

    assign load_data  = load_data_q;
    assign done       = done_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed vector table plus randomized accesses against a lane-arithmetic
// reference model, with hand-written reset/idle-ack sequences.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam logic [2:0] C_LB = 3'b000, C_LH = 3'b001, C_LW = 3'b010,
                           C_LBU = 3'b011, C_LHU = 3'b100, C_LNONE = 3'b111;
    localparam logic [1:0] C_SB = 2'b00, C_SH = 2'b01, C_SW = 2'b10, C_SNONE = 2'b11;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  lt;
        logic [1:0]  stt;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          waits;
        logic        exp_start;
        logic        exp_we;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_ldv;
        logic [31:0] exp_ld;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write, wb_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_store_type;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, done, misaligned;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_ld = 32'd0;

    mem_access_unit_if bus_if ();

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_write      (mem_write),
        .wb_load        (wb_load),
        .mem_load_type  (mem_load_type),
        .mem_store_type (mem_store_type),
        .addr           (addr),
        .store_data     (store_data),
        .load_data      (load_data),
        .stall          (stall),
        .done           (done),
        .misaligned     (misaligned),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check32(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL txn %0d %s: got 0x%08h expected 0x%08h", id, nm, act, exp);
        end
    endtask

    task automatic check1(input int id, input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL txn %0d %s: got %b expected %b", id, nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wb_load = 1'b0; mem_write = 1'b0;
        mem_load_type = C_LNONE; mem_store_type = C_SNONE;
        addr = 32'd0; store_data = 32'd0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(input logic [1:0] stt, input logic [31:0] a);
        logic [3:0] one;
        one = 4'b0001;
        case (stt)
            C_SB:    return one << a[1:0];
            C_SH:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] stt, input logic [31:0] sd);
        case (stt)
            C_SB:    return {24'd0, sd[7:0]} * 32'h0101_0101;
            C_SH:    return {16'd0, sd[15:0]} * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a[1:0])) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        case (lt)
            C_LB:    return (b >= 32'd128)   ? b - 32'd256   : b;
            C_LBU:   return b;
            C_LH:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            C_LHU:   return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic m_mis(input logic li, input logic [2:0] lt, input logic [1:0] stt, input logic [31:0] a);
        if (li) begin
            if (lt == C_LH || lt == C_LHU) return (a % 2) != 0;
            if (lt == C_LW)                return (a % 4) != 0;
            return 1'b0;
        end
        if (stt == C_SH) return (a % 2) != 0;
        if (stt == C_SW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic vec_t mk_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] rd,
                                     input int w, input logic [31:0] exp_ld);
        vec_t v;
        v = '0;
        v.ld = 1'b1; v.lt = lt; v.stt = C_SNONE; v.a = a; v.rd = rd; v.waits = w;
        v.exp_start = 1'b1; v.exp_we = 1'b0; v.exp_addr = a & 32'hFFFF_FFFC;
        v.exp_be = 4'b1111; v.exp_ldv = 1'b1; v.exp_ld = exp_ld;
        return v;
    endfunction

    function automatic vec_t mk_store(input logic [1:0] stt, input logic [31:0] a, input logic [31:0] sd,
                                      input int w, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                      input logic [31:0] exp_wdata);
        vec_t v;
        v = '0;
        v.st = 1'b1; v.lt = C_LNONE; v.stt = stt; v.a = a; v.sd = sd; v.waits = w;
        v.exp_start = 1'b1; v.exp_we = 1'b1; v.exp_addr = exp_addr;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_ldv = 1'b0;
        return v;
    endfunction

    // One complete access: start cycle, REQ cycles with ack after v.waits
    // wait cycles, DONE, then one cycle of IDLE to confirm a single pulse.
    task automatic run_vec(input vec_t v, input int id);
        int          stall_cnt;
        int          req_cnt;
        bit          got_done;
        logic [31:0] exp_ld;
        exp_ld = v.exp_ldv ? v.exp_ld : model_ld;

        @(posedge clk); #1;
        wb_load = v.ld; mem_write = v.st;
        mem_load_type = v.lt; mem_store_type = v.stt;
        addr = v.a; store_data = v.sd;
        bus_if.bus_ack = 1'b0;
        #1;
        check1(id, "stall_start", stall, v.exp_start);
        if (!v.exp_start) begin
            @(posedge clk); #1;
            check1(id, "no_req", bus_if.bus_req, 1'b0);
            check1(id, "no_done", done, 1'b0);
            check1(id, "no_stall", stall, 1'b0);
            clear_inputs();
            $display("[TB] txn %0d no access ld=%b st=%b lt=%03b st_t=%02b", id, v.ld, v.st, v.lt, v.stt);
            return;
        end

        stall_cnt = 1; req_cnt = 0; got_done = 1'b0;
        for (int cyc = 0; cyc < 32 && !got_done; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                got_done = 1'b1;
                bus_if.bus_ack = 1'b0;
                check1(id, "stall_done", stall, 1'b0);
                check1(id, "req_done", bus_if.bus_req, 1'b0);
                check1(id, "misaligned", misaligned, v.exp_mis);
                check32(id, "load_data", load_data, exp_ld);
            end else begin
                check1(id, "req", bus_if.bus_req, 1'b1);
                check1(id, "stall_req", stall, 1'b1);
                if (stall) stall_cnt++;
                if (req_cnt == 0) begin
                    check32(id, "bus_addr", bus_if.bus_addr, v.exp_addr);
                    check32(id, "bus_be", {28'd0, bus_if.bus_be}, {28'd0, v.exp_be});
                    check1(id, "bus_we", bus_if.bus_we, v.exp_we);
                    if (v.exp_we) check32(id, "bus_wdata", bus_if.bus_wdata, v.exp_wdata);
                end
                if (req_cnt == v.waits) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.bus_rdata = v.rd;
                end else begin
                    bus_if.bus_ack = 1'b0;
                    bus_if.bus_rdata = $urandom;
                end
                req_cnt++;
            end
        end
        check1(id, "done_seen", got_done, 1'b1);
        check32(id, "req_cycles", req_cnt, v.exp_mis ? 0 : v.waits + 1);
        check32(id, "stall_cycles", stall_cnt, v.exp_mis ? 1 : v.waits + 2);
        model_ld = exp_ld;

        // Inputs were still presented during DONE; they must not retrigger.
        @(posedge clk); #1;
        clear_inputs();
        bus_if.bus_ack = 1'b0;
        check1(id, "single_done", done, 1'b0);
        check1(id, "no_retrigger", bus_if.bus_req, 1'b0);
        $display("[TB] txn %0d %s lt=%03b st_t=%02b addr=0x%08h waits=%0d mis=%b load_data=0x%08h",
                 id, v.exp_we ? "store" : "load ", v.lt, v.stt, v.a, v.waits, v.exp_mis, load_data);
    endtask

    vec_t tbl [10];

    initial begin
        rst = 1'b1;
        clear_inputs();
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = 32'd0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check32(0, "rst_load_data", load_data, 32'd0);
        check1(0, "rst_bus_req", bus_if.bus_req, 1'b0);
        check1(0, "rst_bus_we", bus_if.bus_we, 1'b0);
        check32(0, "rst_bus_addr", bus_if.bus_addr, 32'd0);
        check32(0, "rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        check32(0, "rst_bus_be", {28'd0, bus_if.bus_be}, 32'd0);
        check1(0, "rst_done", done, 1'b0);
        check1(0, "rst_misaligned", misaligned, 1'b0);
        check1(0, "rst_stall", stall, 1'b0);
        rst = 1'b0;
        $display("[TB] txn 0 reset state");

        // ---------------- ack while idle is ignored ----------------
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 32'hCAFE_F00D;
        repeat (2) begin
            @(posedge clk); #1;
            check1(1, "idle_ack_done", done, 1'b0);
            check1(1, "idle_ack_req", bus_if.bus_req, 1'b0);
        end
        bus_if.bus_ack = 1'b0;
        $display("[TB] txn 1 idle ack ignored");

        // ---------------- directed table ----------------
        tbl[0] = mk_store(C_SB, 32'h0000_1002, 32'h1122_3344, 2, 32'h0000_1000, 4'b0100, 32'h4444_4444);
        tbl[1] = mk_load(C_LB,  32'h0000_2003, 32'h80FF_0000, 0, 32'hFFFF_FF80);
        tbl[2] = mk_load(C_LBU, 32'h0000_2003, 32'h80FF_0000, 0, 32'h0000_0080);
        tbl[3] = mk_load(C_LH,  32'h0000_2002, 32'h8001_1234, 1, 32'hFFFF_8001);
        tbl[4] = mk_load(C_LHU, 32'h0000_2000, 32'h8001_1234, 0, 32'h0000_1234);
        tbl[5] = mk_load(C_LW,  32'h0000_2000, 32'h8001_1234, 3, 32'h8001_1234);
        // load and store together: load wins
        tbl[6] = mk_load(C_LW,  32'h0000_2004, 32'h1357_2468, 0, 32'h1357_2468);
        tbl[6].st = 1'b1; tbl[6].stt = C_SW; tbl[6].sd = 32'h5555_5555;
        // store with type none: no access
        tbl[7] = mk_store(C_SNONE, 32'h0000_2008, 32'h0, 0, 32'h0, 4'b0, 32'h0);
        tbl[7].exp_start = 1'b0;
        tbl[8] = mk_store(C_SH, 32'h0000_2006, 32'hAABB_CCDD, 1, 32'h0000_2004, 4'b1100, 32'hCCDD_CCDD);
`ifdef MISALIGN_TRAP_EN
        tbl[9] = mk_store(C_SW, 32'h0000_3001, 32'hDEAD_BEEF, 0, 32'h0, 4'b0, 32'h0);
        tbl[9].exp_mis = 1'b1;
`else
        tbl[9] = mk_store(C_SW, 32'h0000_3001, 32'hDEAD_BEEF, 1, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF);
`endif
        for (int i = 0; i < 10; i++) run_vec(tbl[i], 10 + i);

        // ---------------- randomized accesses ----------------
        for (int i = 0; i < 40; i++) begin
            vec_t        v;
            logic [31:0] r;
            logic        li, si;
            v = '0;
            r = $urandom;
            v.ld = r[0]; v.st = r[1];
            case (r[6:4] % 3'd6)
                3'd0: v.lt = C_LB;  3'd1: v.lt = C_LH;  3'd2: v.lt = C_LW;
                3'd3: v.lt = C_LBU; 3'd4: v.lt = C_LHU; default: v.lt = C_LNONE;
            endcase
            v.stt = r[9:8];
            v.a = {16'h0, r[31:16]};
            v.sd = $urandom;
            v.rd = $urandom;
            v.waits = int'(r[11:10]);
            li = v.ld && (v.lt != C_LNONE);
            si = v.st && (v.stt != C_SNONE);
            v.exp_start = li || si;
            v.exp_we = !li;
`ifdef MISALIGN_TRAP_EN
            v.exp_mis = v.exp_start && m_mis(li, v.lt, v.stt, v.a);
`else
            v.exp_mis = 1'b0;
`endif
            v.exp_addr = v.a & 32'hFFFF_FFFC;
            v.exp_be = li ? 4'b1111 : m_be(v.stt, v.a);
            v.exp_wdata = m_wdata(v.stt, v.sd);
            v.exp_ldv = li && !v.exp_mis;
            v.exp_ld = m_load(v.lt, v.a, v.rd);
            run_vec(v, 100 + i);
        end

        // ---------------- reset while REQ, ack withheld ----------------
        @(posedge clk); #1;
        wb_load = 1'b1; mem_load_type = C_LW; addr = 32'h0000_4000;
        bus_if.bus_ack = 1'b0;
        @(posedge clk); #1;
        check1(200, "rst_mid_req_before", bus_if.bus_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check1(200, "rst_mid_req_after", bus_if.bus_req, 1'b0);
        rst = 1'b0;
        clear_inputs();
        #1;
        check1(200, "rst_mid_stall", stall, 1'b0);
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(posedge clk); #1;
            check1(200, "late_ack_done", done, 1'b0);
            check1(200, "late_ack_req", bus_if.bus_req, 1'b0);
            check32(200, "late_ack_load_data", load_data, 32'd0);
        end
        bus_if.bus_ack = 1'b0;
        $display("[TB] txn 200 reset mid-request, late ack ignored");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
